// File: rtl/sgmii_meas_pkg.sv
// Shared constants for the SGMII clock-activity measurement sequencer:
// channel count, counter width, enable field position, FSM state codes and
// a slice helper for the packed per-channel 96-bit buses.
package sgmii_meas_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned EN_LSB = 16;
  localparam int unsigned BUS_W  = NUM_CH * CNT_W;

  typedef logic [2:0] meas_state_t;

  localparam meas_state_t ST_IDLE   = 3'd0;
  localparam meas_state_t ST_SNAP_S = 3'd1;
  localparam meas_state_t ST_GATE   = 3'd2;
  localparam meas_state_t ST_SETTLE = 3'd3;
  localparam meas_state_t ST_SNAP_E = 3'd4;
  localparam meas_state_t ST_DONE   = 3'd5;

  // Channel ch occupies bits [ch*CNT_W +: CNT_W] of every packed bus.
  function automatic logic [CNT_W-1:0] ch_slice(input logic [BUS_W-1:0] bus,
                                                input int unsigned     ch);
    return bus[ch*CNT_W +: CNT_W];
  endfunction

endpackage

// File: rtl/sgmii_snap_stable.sv
// Per-channel snapshot stabiliser. While sample_en is high it samples the
// live count every cycle; two equal consecutive samples mark the channel
// stable and hold that value. If STAB_MAX samples pass without a match the
// timeout flag rises and sampling stops. clear restarts the procedure.
module sgmii_snap_stable
  import sgmii_meas_pkg::*;
#(
  parameter int unsigned STAB_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] value,
  output logic             stable,
  output logic             timeout
);

  localparam int unsigned TW = $clog2(STAB_MAX + 2);

  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] value_q;
  logic             have_prev_q;
  logic             stable_q;
  logic [TW-1:0]    tcnt_q;

  assign timeout = !stable_q && (tcnt_q == TW'(STAB_MAX));
  assign stable  = stable_q;
  assign value   = value_q;

  // Sample/compare sequence; frozen once stable or timed out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_q      <= '0;
      value_q     <= '0;
      have_prev_q <= 1'b0;
      stable_q    <= 1'b0;
      tcnt_q      <= '0;
    end else if (sample_en && !stable_q && !timeout) begin
      prev_q      <= cnt;
      have_prev_q <= 1'b1;
      tcnt_q      <= tcnt_q + 1'b1;
      if (have_prev_q && (cnt == prev_q)) begin
        stable_q <= 1'b1;
        value_q  <= cnt;
      end
    end
  end

endmodule

// File: rtl/sgmii_clk_meas_ctrl.sv
// Sequencer for the SGMII clock-activity counters (mdc, gmii_txclk,
// gmii_rxclk). Takes a stable start snapshot, opens a timed enable gate,
// waits for the enables to drain into the counter domains, takes a stable
// end snapshot and reports modulo-2^32 deltas checked against limits.
// Optional build macro SGMII_MEAS_IRQ_EN adds a sticky failure interrupt
// (irq) with its clear input (irq_clr).
module sgmii_clk_meas_ctrl
  import sgmii_meas_pkg::*;
#(
  parameter int unsigned SYNC_CYCLES = 8,
  parameter int unsigned STAB_MAX    = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CNT_W-1:0]  gate_cycles,
  input  logic [BUS_W-1:0]  lim_min,
  input  logic [BUS_W-1:0]  lim_max,
  input  logic [CNT_W-1:0]  mdc_cnt,
  input  logic [CNT_W-1:0]  gmii_txclk_cnt,
  input  logic [CNT_W-1:0]  gmii_rxclk_cnt,
  output logic [CNT_W-1:0]  cnt_ctrl,
  output logic              busy,
  output logic              done,
  output logic [BUS_W-1:0]  delta,
  output logic [NUM_CH-1:0] pass,
`ifdef SGMII_MEAS_IRQ_EN
  input  logic              irq_clr,
  output logic              irq,
`endif
  output logic [NUM_CH-1:0] unstable
);

  localparam logic [CNT_W-1:0] SETTLE_LEN = (SYNC_CYCLES == 0) ? CNT_W'(1) : CNT_W'(SYNC_CYCLES);

  meas_state_t       state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [NUM_CH-1:0] mask_q;
  logic [CNT_W-1:0]  gate_q;
  logic [BUS_W-1:0]  lim_min_q, lim_max_q;
  logic [CNT_W-1:0]  start_val_q [NUM_CH];
  logic [NUM_CH-1:0] unst_acc_q;
  logic [BUS_W-1:0]  delta_q, delta_n;
  logic [NUM_CH-1:0] pass_q, pass_n;
  logic [NUM_CH-1:0] unst_q, unst_n;

  logic [CNT_W-1:0]  cnt_arr    [NUM_CH];
  logic [CNT_W-1:0]  snap_value [NUM_CH];
  logic [CNT_W-1:0]  diff       [NUM_CH];
  logic [NUM_CH-1:0] snap_stable, snap_timeout, sample_en;
  logic [NUM_CH-1:0] snap_fail, unst_fin;
  logic              snap_state, snap_clear, all_done, load;

  assign cnt_arr[0] = mdc_cnt;
  assign cnt_arr[1] = gmii_txclk_cnt;
  assign cnt_arr[2] = gmii_rxclk_cnt;

  assign snap_state = (state_q == ST_SNAP_S) || (state_q == ST_SNAP_E);
  assign sample_en  = snap_state ? mask_q : '0;
  // Restart the stabilisers on every entry into a snapshot state.
  assign snap_clear = ((state_d == ST_SNAP_S) || (state_d == ST_SNAP_E)) && (state_d != state_q);
  // Unmasked channels never hold up a snapshot.
  assign all_done   = &(~mask_q | snap_stable | snap_timeout);
  assign snap_fail  = mask_q & ~snap_stable;
  assign unst_fin   = unst_acc_q | snap_fail;
  assign load       = (state_q == ST_IDLE) && start && !abort;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_snap
    sgmii_snap_stable #(
      .STAB_MAX (STAB_MAX)
    ) u_snap (
      .clk       (ACLK),
      .rst       (ARESET),
      .clear     (snap_clear),
      .sample_en (sample_en[i]),
      .cnt       (cnt_arr[i]),
      .value     (snap_value[i]),
      .stable    (snap_stable[i]),
      .timeout   (snap_timeout[i])
    );
  end

  // Next-state and shared timer (gate length, then settle length); abort overrides all.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SNAP_S;
      end
      ST_SNAP_S: begin
        if (all_done) begin
          state_d = ST_GATE;
          timer_d = (gate_q == '0) ? CNT_W'(1) : gate_q;
        end
      end
      ST_GATE: begin
        if (timer_q <= CNT_W'(1)) begin
          state_d = ST_SETTLE;
          timer_d = SETTLE_LEN;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (timer_q <= CNT_W'(1)) state_d = ST_SNAP_E;
        else timer_d = timer_q - CNT_W'(1);
      end
      ST_SNAP_E: begin
        if (all_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = continuous ? ST_SNAP_S : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Run results from the end snapshot; channels that never stabilised report zero.
  always_comb begin
    delta_n = '0;
    pass_n  = '0;
    unst_n  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      diff[i] = snap_value[i] - start_val_q[i];
      if (mask_q[i] && !unst_fin[i]) begin
        delta_n[i*CNT_W +: CNT_W] = diff[i];
        pass_n[i] = (diff[i] >= ch_slice(lim_min_q, i)) && (diff[i] <= ch_slice(lim_max_q, i));
      end
      unst_n[i] = mask_q[i] & unst_fin[i];
    end
  end

  // FSM state, timer and run configuration latched at start.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      mask_q    <= '0;
      gate_q    <= '0;
      lim_min_q <= '0;
      lim_max_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (load) begin
        mask_q    <= ch_mask;
        gate_q    <= gate_cycles;
        lim_min_q <= lim_min;
        lim_max_q <= lim_max;
      end
    end
  end

  // Start snapshot capture and per-run unstable accumulation.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      unst_acc_q <= '0;
      for (int i = 0; i < NUM_CH; i++) start_val_q[i] <= '0;
    end else if ((state_d == ST_SNAP_S) && (state_q != ST_SNAP_S)) begin
      unst_acc_q <= '0;
    end else if ((state_q == ST_SNAP_S) && (state_d == ST_GATE)) begin
      unst_acc_q <= snap_fail;
      for (int i = 0; i < NUM_CH; i++) start_val_q[i] <= snap_value[i];
    end
  end

  // Published results change only on entry to DONE, so they line up with the done pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      delta_q <= '0;
      pass_q  <= '0;
      unst_q  <= '0;
    end else if ((state_q == ST_SNAP_E) && (state_d == ST_DONE)) begin
      delta_q <= delta_n;
      pass_q  <= pass_n;
      unst_q  <= unst_n;
    end
  end

  // Enables are driven only while gating.
  always_comb begin
    cnt_ctrl = '0;
    if (state_q == ST_GATE) cnt_ctrl[EN_LSB +: NUM_CH] = mask_q;
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign delta    = delta_q;
  assign pass     = pass_q;
  assign unstable = unst_q;

`ifdef SGMII_MEAS_IRQ_EN
  logic irq_q;

  // Sticky failure flag; a new failure outranks a simultaneous clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_q <= 1'b0;
    end else if ((state_q == ST_DONE) && (|(mask_q & ~pass_q))) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sgmii_clk_meas_ctrl.sv
// Directed self-checking bench for sgmii_clk_meas_ctrl. Counter inputs are
// driven directly: held still during snapshots, stepped once the gate opens.
module tb_sgmii_clk_meas_ctrl;

  localparam int SYNC = 8;
  localparam int STAB = 64;
  localparam int SNAP_FROZEN = 3;  // frozen counter: first sample, matching sample, exit

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         start, abort, continuous;
  logic [2:0]   ch_mask;
  logic [31:0]  gate_cycles;
  logic [95:0]  lim_min, lim_max;
  logic [31:0]  mdc_cnt, gmii_txclk_cnt, gmii_rxclk_cnt;
  logic [31:0]  cnt_ctrl;
  logic         busy, done;
  logic [95:0]  delta;
  logic [2:0]   pass, unstable;
`ifdef SGMII_MEAS_IRQ_EN
  logic         irq_clr, irq;
`endif

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  sgmii_clk_meas_ctrl #(
    .SYNC_CYCLES (SYNC),
    .STAB_MAX    (STAB)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .start          (start),
    .abort          (abort),
    .continuous     (continuous),
    .ch_mask        (ch_mask),
    .gate_cycles    (gate_cycles),
    .lim_min        (lim_min),
    .lim_max        (lim_max),
    .mdc_cnt        (mdc_cnt),
    .gmii_txclk_cnt (gmii_txclk_cnt),
    .gmii_rxclk_cnt (gmii_rxclk_cnt),
    .cnt_ctrl       (cnt_ctrl),
    .busy           (busy),
    .done           (done),
    .delta          (delta),
    .pass           (pass),
`ifdef SGMII_MEAS_IRQ_EN
    .irq_clr        (irq_clr),
    .irq            (irq),
`endif
    .unstable       (unstable)
  );

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic pulse_start(input logic [2:0] m, input logic [31:0] g);
    ch_mask = m;
    gate_cycles = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_gate(input int max, output bit seen);
    int n;
    n = 0;
    while (cnt_ctrl[18:16] == 3'b000 && n < max) begin
      tick();
      n++;
    end
    seen = (cnt_ctrl[18:16] != 3'b000);
  endtask

  task automatic count_gate(output int n);
    n = 0;
    while (cnt_ctrl !== 32'h0 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_done(input int max, output bit seen, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
    seen = (done === 1'b1);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) tick();
    total++; if (cnt_ctrl !== 32'h0) begin bad++; $display("FAIL reset_cnt_ctrl got %h want 0", cnt_ctrl); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    total++; if (delta !== 96'h0) begin bad++; $display("FAIL reset_delta got %h want 0", delta); end
    total++; if (pass !== 3'b000 || unstable !== 3'b000) begin bad++; $display("FAIL reset_flags got %b/%b want 000/000", pass, unstable); end
    ARESET = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit seen; int n, cyc;
    mdc_cnt = 32'd5; gmii_txclk_cnt = 32'd7; gmii_rxclk_cnt = 32'd9;
    lim_min = {32'd120, 32'd120, 32'd1};
    lim_max = {32'd130, 32'd130, 32'd2};
    pulse_start(3'b111, 32'd100);
    wait_gate(20, seen);
    total++; if (!seen) begin bad++; $display("FAIL basic_gate_open got 0 want 1"); end
    total++; if (cnt_ctrl !== 32'h0007_0000) begin bad++; $display("FAIL basic_cnt_ctrl got %h want 00070000", cnt_ctrl); end
    mdc_cnt = 32'd6; gmii_txclk_cnt = 32'd132; gmii_rxclk_cnt = 32'd134;
    count_gate(n);
    total++; if (n !== 100) begin bad++; $display("FAIL basic_gate_len got %0d want 100", n); end
    wait_done(200, seen, cyc);
    total++; if (!seen || cyc !== SYNC + SNAP_FROZEN) begin bad++; $display("FAIL basic_done_latency got %0d (seen %b) want %0d", cyc, seen, SYNC + SNAP_FROZEN); end
    total++; if (delta !== {32'd125, 32'd125, 32'd1}) begin bad++; $display("FAIL basic_delta got %h want %h", delta, {32'd125, 32'd125, 32'd1}); end
    total++; if (pass !== 3'b111 || unstable !== 3'b000) begin bad++; $display("FAIL basic_flags got %b/%b want 111/000", pass, unstable); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_one_pulse got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_wrap();
    bit seen; int n, cyc;
    mdc_cnt = 32'hFFFF_FFF0; gmii_txclk_cnt = 32'd11; gmii_rxclk_cnt = 32'd22;
    lim_min = {32'd0, 32'd0, 32'h10};
    lim_max = {32'd0, 32'd0, 32'h30};
    pulse_start(3'b001, 32'd50);
    wait_gate(20, seen);
    total++; if (cnt_ctrl !== 32'h0001_0000) begin bad++; $display("FAIL wrap_cnt_ctrl got %h want 00010000", cnt_ctrl); end
    mdc_cnt = 32'h10; gmii_txclk_cnt = 32'd900; gmii_rxclk_cnt = 32'd901;
    count_gate(n);
    wait_done(200, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL wrap_done got 0 want 1"); end
    total++; if (delta !== {64'h0, 32'h20}) begin bad++; $display("FAIL wrap_delta got %h want %h", delta, {64'h0, 32'h20}); end
    total++; if (pass !== 3'b001 || unstable !== 3'b000) begin bad++; $display("FAIL wrap_flags got %b/%b want 001/000", pass, unstable); end
    tick();
  endtask

  task automatic test_unstable();
    bit seen; int n, cyc;
    mdc_cnt = 32'd100; gmii_txclk_cnt = 32'd200; gmii_rxclk_cnt = 32'd300;
    lim_min = {32'd40, 32'd40, 32'd40};
    lim_max = {32'd60, 32'd60, 32'd60};
    pulse_start(3'b111, 32'd30);
    wait_gate(20, seen);
    mdc_cnt = 32'd150; gmii_rxclk_cnt = 32'd350;
    count_gate(n);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      gmii_txclk_cnt = gmii_txclk_cnt + 32'd1;
      tick();
      cyc++;
    end
    total++; if (done !== 1'b1 || cyc !== SYNC + STAB + 1) begin bad++; $display("FAIL unst_done_latency got %0d want %0d", cyc, SYNC + STAB + 1); end
    total++; if (unstable !== 3'b010) begin bad++; $display("FAIL unst_flags got %b want 010", unstable); end
    total++; if (pass !== 3'b101) begin bad++; $display("FAIL unst_pass got %b want 101", pass); end
    total++; if (delta !== {32'd50, 32'd0, 32'd50}) begin bad++; $display("FAIL unst_delta got %h want %h", delta, {32'd50, 32'd0, 32'd50}); end
    tick();
  endtask

  task automatic test_abort();
    bit seen; int dones;
    lim_min = '0; lim_max = '0;
    pulse_start(3'b111, 32'd100);
    wait_gate(20, seen);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (cnt_ctrl !== 32'h0 || busy !== 1'b0) begin bad++; $display("FAIL abort_stop got ctrl=%h busy=%b want 0 0", cnt_ctrl, busy); end
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", dones); end
    total++; if (delta !== {32'd50, 32'd0, 32'd50} || pass !== 3'b101 || unstable !== 3'b010) begin
      bad++; $display("FAIL abort_hold got %h %b %b want prior results", delta, pass, unstable);
    end
  endtask

  task automatic test_start_busy();
    bit seen; int n, cyc;
    lim_min = '0; lim_max = '0;
    pulse_start(3'b001, 32'd20);
    wait_gate(20, seen);
    ch_mask = 3'b111; gate_cycles = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (cnt_ctrl !== 32'h0001_0000) begin bad++; $display("FAIL busy_start_ctrl got %h want 00010000", cnt_ctrl); end
    count_gate(n);
    total++; if (n !== 19) begin bad++; $display("FAIL busy_start_gate got %0d want 19", n); end
    wait_done(200, seen, cyc);
    total++; if (!seen || pass !== 3'b001 || delta !== 96'h0) begin bad++; $display("FAIL busy_start_result got %b %h want 001 0", pass, delta); end
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_idle got %b want 0", busy); end
  endtask

  task automatic test_continuous();
    bit seen; int cyc, dones;
    lim_min = '0; lim_max = '0;
    continuous = 1'b1;
    pulse_start(3'b001, 32'd10);
    wait_done(100, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL cont_first_done got 0 want 1"); end
    for (int k = 0; k < 2; k++) begin
      tick();
      wait_done(100, seen, cyc);
      total++; if (!seen || cyc + 1 !== 10 + SYNC + 2 * SNAP_FROZEN + 1) begin
        bad++; $display("FAIL cont_period got %0d want %0d", cyc + 1, 10 + SYNC + 2 * SNAP_FROZEN + 1);
      end
    end
    continuous = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop got busy=%b want 0", busy); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL cont_no_more got %0d want 0", dones); end
  endtask

  task automatic test_mask0();
    int cyc, en_seen;
    lim_min = '0; lim_max = {96{1'b1}};
    pulse_start(3'b000, 32'd5);
    cyc = 0; en_seen = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (cnt_ctrl !== 32'h0) en_seen++;
      tick();
      cyc++;
    end
    total++; if (done !== 1'b1 || en_seen !== 0) begin bad++; $display("FAIL mask0_run got done=%b en=%0d want 1 0", done, en_seen); end
    total++; if (delta !== 96'h0 || pass !== 3'b000 || unstable !== 3'b000) begin
      bad++; $display("FAIL mask0_result got %h %b %b want zeros", delta, pass, unstable);
    end
    tick();
  endtask

  task automatic test_gate0();
    bit seen; int n, cyc;
    mdc_cnt = 32'd1000;
    lim_min = {64'h0, 32'd3}; lim_max = {64'h0, 32'd3};
    pulse_start(3'b001, 32'd0);
    wait_gate(20, seen);
    mdc_cnt = 32'd1003;
    count_gate(n);
    total++; if (n !== 1) begin bad++; $display("FAIL gate0_len got %0d want 1", n); end
    wait_done(200, seen, cyc);
    total++; if (!seen || delta !== {64'h0, 32'd3} || pass !== 3'b001) begin bad++; $display("FAIL gate0_result got %h %b want 3 001", delta, pass); end
    tick();
  endtask

  task automatic test_reset_midrun();
    bit seen;
    pulse_start(3'b111, 32'd100);
    wait_gate(20, seen);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    total++; if (busy !== 1'b0 || cnt_ctrl !== 32'h0 || done !== 1'b0) begin bad++; $display("FAIL midreset_state got busy=%b ctrl=%h want 0 0", busy, cnt_ctrl); end
    total++; if (delta !== 96'h0 || pass !== 3'b000 || unstable !== 3'b000) begin bad++; $display("FAIL midreset_results got %h %b %b want zeros", delta, pass, unstable); end
    tick();
  endtask

`ifdef SGMII_MEAS_IRQ_EN
  task automatic test_irq();
    bit seen; int cyc;
    lim_min = {64'h0, 32'd5}; lim_max = {64'h0, 32'd5};
    pulse_start(3'b001, 32'd4);
    wait_done(100, seen, cyc);
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got %b want 1", irq); end
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", irq); end
    pulse_start(3'b001, 32'd4);
    wait_done(100, seen, cyc);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins got %b want 1", irq); end
    tick();
  endtask
`endif

  initial begin
    ARESET = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    ch_mask = 3'b000; gate_cycles = 32'd0; lim_min = '0; lim_max = '0;
    mdc_cnt = 32'd0; gmii_txclk_cnt = 32'd0; gmii_rxclk_cnt = 32'd0;
`ifdef SGMII_MEAS_IRQ_EN
    irq_clr = 1'b0;
`endif
    tick();
    test_reset();
    test_basic();
    test_wrap();
    test_unstable();
    test_abort();
    test_start_busy();
    test_continuous();
    test_mask0();
    test_gate0();
    test_reset_midrun();
`ifdef SGMII_MEAS_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
